// File: rtl/cmd_deframer_pkg.sv
// Shared types for the command deframer: word width, sync default, FSM states, checksum helper.
// Build option: CMD_DEFRAMER_CKSUM_EN adds a trailing XOR checksum byte and the S_CKSUM state.
package cmd_deframer_pkg;

  localparam int CMD_W = 32;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

`ifdef CMD_DEFRAMER_CKSUM_EN
  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_COLLECT = 2'd1,
    S_PUSH    = 2'd2,
    S_CKSUM   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_COLLECT = 2'd1,
    S_PUSH    = 2'd2
  } state_t;
`endif

  function automatic logic [7:0] xor_bytes(input logic [CMD_W-1:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

endpackage

// File: rtl/cmd_deframer_if.sv
// Byte-stream input and command-word output bundle of the deframer.
// Build option CMD_DEFRAMER_CKSUM_EN does not change this interface.
interface cmd_deframer_if;
  import cmd_deframer_pkg::*;

  // byte_valid is a 1-cycle strobe with no backpressure; a cmd word transfers on
  // any cycle with cmd_rdreq=1 and cmd_waitreq=0 (cmd_rdreq is ignored while waitreq=1).
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic [CMD_W-1:0] cmd_data;
  logic             cmd_waitreq;
  logic             cmd_rdreq;

  modport master (
    output byte_data, byte_valid, cmd_rdreq,
    input  cmd_data, cmd_waitreq
  );

  modport slave (
    input  byte_data, byte_valid, cmd_rdreq,
    output cmd_data, cmd_waitreq
  );

endinterface

// File: rtl/cmd_sfifo.sv
// Synchronous show-ahead FIFO: head word is presented on dout whenever not empty.
// Unaffected by CMD_DEFRAMER_CKSUM_EN.
module cmd_sfifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                rd_en;
  logic                wr_en;

  // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign rd_en = rd && !empty;
  assign wr_en = wr && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_deframer.sv
// Sync-hunting byte deframer assembling 32-bit command words into a show-ahead FIFO.
// Build option: CMD_DEFRAMER_CKSUM_EN enables the trailing XOR checksum byte.
module cmd_deframer
  import cmd_deframer_pkg::*;
#(
  parameter int         DEPTH_LOG2  = 4,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  cmd_deframer_if.slave       bus,
  output logic                frame_err,
  output logic [7:0]          ovf_cnt,
  output logic [DEPTH_LOG2:0] fifo_level,
  output state_t              state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CMD_W-1:0] word, word_nxt;
  logic [TW-1:0]    tmo_cnt, tmo_nxt;
  logic             err_nxt;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign state_dbg       = state;
  assign bus.cmd_waitreq = fifo_empty;
  assign pop             = bus.cmd_rdreq && !fifo_empty;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    word_nxt  = word;
    tmo_nxt   = '0;
    err_nxt   = 1'b0;
    push      = 1'b0;
    case (state)
      // The push cycle also hunts, so back-to-back frames lose no bytes.
      S_HUNT, S_PUSH: begin
        push = (state == S_PUSH);
        if (bus.byte_valid && bus.byte_data == SYNC_BYTE) begin
          state_nxt = S_COLLECT;
          idx_nxt   = 2'd3;
        end else begin
          state_nxt = S_HUNT;
        end
      end
      S_COLLECT: begin
        if (bus.byte_valid) begin
          word_nxt[{idx, 3'b000} +: 8] = bus.byte_data;
          idx_nxt = idx - 2'd1;
          if (idx == 2'd0) begin
`ifdef CMD_DEFRAMER_CKSUM_EN
            state_nxt = S_CKSUM;
`else
            state_nxt = S_PUSH;
`endif
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = S_HUNT;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
`ifdef CMD_DEFRAMER_CKSUM_EN
      S_CKSUM: begin
        if (bus.byte_valid) begin
          if (bus.byte_data == xor_bytes(word)) begin
            state_nxt = S_PUSH;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_HUNT;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = S_HUNT;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
`endif
      default: state_nxt = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HUNT;
      idx       <= 2'd3;
      word      <= '0;
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      word      <= word_nxt;
      tmo_cnt   <= tmo_nxt;
      frame_err <= err_nxt;
    end
  end

  // A push into a full FIFO only counts as an overflow if no pop frees a slot that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (push && fifo_full && !pop && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  cmd_sfifo #(
    .WIDTH      (CMD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (push),
    .rd    (bus.cmd_rdreq),
    .din   (word),
    .dout  (bus.cmd_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_cmd_deframer.sv
// Directed plus randomized bench for cmd_deframer against a queue-based frame model.
// Honors CMD_DEFRAMER_CKSUM_EN to build frames with or without the checksum byte.
module tb_cmd_deframer;
  import cmd_deframer_pkg::*;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;
  localparam int TMO   = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_deframer_if bus();
  logic          frame_err;
  logic [7:0]    ovf_cnt;
  logic [DL:0]   fifo_level;
  state_t        state_dbg;

  cmd_deframer #(
    .DEPTH_LOG2  (DL),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .frame_err  (frame_err),
    .ovf_cnt    (ovf_cnt),
    .fifo_level (fifo_level),
    .state_dbg  (state_dbg)
  );

  logic [31:0] exp_q[$];
  int exp_ovf  = 0;
  int exp_err  = 0;
  int err_seen = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge clk) if (rst_n && frame_err) err_seen = err_seen + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_level"}, 32'(fifo_level), 32'(exp_q.size()));
    chk({tag, "_waitreq"}, 32'(bus.cmd_waitreq), (exp_q.size() == 0) ? 32'd1 : 32'd0);
    chk({tag, "_data"}, bus.cmd_data, (exp_q.size() == 0) ? 32'd0 : exp_q[0]);
    chk({tag, "_ovf"}, 32'(ovf_cnt), 32'(exp_ovf));
    chk({tag, "_err"}, 32'(err_seen), 32'(exp_err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
  endtask

  function automatic void model_push(input logic [31:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else if (exp_ovf < 255) exp_ovf++;
  endfunction

  function automatic logic [7:0] cksum_of(input logic [31:0] w);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 4; i++) c = c ^ w[8*i +: 8];
    return c;
  endfunction

  // Sends a whole frame, then spends the push cycle, optionally popping during it.
  task automatic send_frame(input logic [31:0] w, input int max_gap, input bit pop_on_push);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, max_gap));
      send_byte(w[31-8*i -: 8]);
    end
`ifdef CMD_DEFRAMER_CKSUM_EN
    idle($urandom_range(0, max_gap));
    send_byte(cksum_of(w));
`endif
    if (pop_on_push) begin
      chk("pop_on_push_data", bus.cmd_data, exp_q[0]);
      bus.cmd_rdreq = 1'b1;
    end
    tick();
    bus.cmd_rdreq = 1'b0;
    if (pop_on_push) void'(exp_q.pop_front());
    model_push(w);
  endtask

  task automatic pop_one(input string tag);
    chk({tag, "_pop_data"}, bus.cmd_data, exp_q[0]);
    bus.cmd_rdreq = 1'b1;
    tick();
    bus.cmd_rdreq = 1'b0;
    void'(exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] w;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.cmd_rdreq  = 1'b0;

    // Reset state
    idle(3);
    check_status("reset");
    chk("reset_state", 32'(state_dbg), 32'(S_HUNT));
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: basic frame and push latency
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
`ifdef CMD_DEFRAMER_CKSUM_EN
    send_byte(8'h08);
`endif
    chk("t1_push_cycle_waitreq", 32'(bus.cmd_waitreq), 32'd1);
    tick();
    model_push(32'h12345678);
    chk("t1_word", bus.cmd_data, 32'h12345678);
    check_status("t1");
    pop_one("t1");
    check_status("t1_after_pop");

    // 2: garbage ahead of a valid frame
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    send_frame($urandom(), 2, 1'b0);
    check_status("t2");
    pop_one("t2");

    // 3: timeout mid-frame, then recovery
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    idle(TMO - 2);
    chk("t3_no_early_err", 32'(err_seen), 32'(exp_err));
    idle(4);
    exp_err++;
    chk("t3_state_hunt", 32'(state_dbg), 32'(S_HUNT));
    check_status("t3_timeout");
    send_frame(32'hCAFEF00D, 3, 1'b0);
    check_status("t3_recover");
    pop_one("t3");

    // 4: bad checksum (or ignored trailing byte without checksum)
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h00);
`ifdef CMD_DEFRAMER_CKSUM_EN
    exp_err++;
`else
    model_push(32'h11223344);
`endif
    idle(2);
    check_status("t4");
    while (exp_q.size() > 0) pop_one("t4_drain");

    // Randomized frames, garbage and pops
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
            w[7:0] = 8'($urandom_range(0, 255));
            if (w[7:0] == 8'hA5) w[7:0] = 8'h5A;
            send_byte(w[7:0]);
          end
        end
        1: send_frame($urandom(), TMO / 4, 1'b0);
        default: if (exp_q.size() > 0) pop_one("rand");
      endcase
      idle($urandom_range(0, 2));
      check_status("rand");
    end
    while (exp_q.size() > 0) pop_one("rand_drain");

    // 5: fill to full, one overflow, then pop coinciding with push
    for (int f = 0; f < DEPTH + 1; f++) send_frame($urandom(), 0, 1'b0);
    check_status("t5_full");
    send_frame($urandom(), 0, 1'b1);
    check_status("t5_pop_on_push");

    // Overflow counter saturation
    for (int f = 0; f < 260; f++) send_frame($urandom(), 0, 1'b0);
    check_status("ovf_saturate");

    // 6: async reset mid-frame with 3 words queued
    while (exp_q.size() > 3) pop_one("t6_trim");
    check_status("t6_before");
    send_byte(8'hA5); send_byte(8'h12);
    #3 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 0;
    check_status("t6_in_reset");
    chk("t6_state", 32'(state_dbg), 32'(S_HUNT));
    tick();
    rst_n = 1'b1;
    idle(1);
    send_frame(32'h0BADBEEF, 1, 1'b0);
    check_status("t6_after");
    pop_one("t6");
    check_status("t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
